// File: rtl/denormalizer_if.sv
// denormalizer_if: start/busy/done request bus between a requester and the denormalizer
//   master: drives start, in_mant, in_exp; receives out_val, busy, done, err
//   slave : the denormalizer side
interface denormalizer_if #(parameter int n = 8);
  logic         start;
  logic [n-1:0] in_mant;
  logic [n-1:0] in_exp;
  logic [n-1:0] out_val;
  logic         busy;
  logic         done;
  logic         err;
  modport master (output start, in_mant, in_exp, input out_val, busy, done, err);
  modport slave  (input start, in_mant, in_exp, output out_val, busy, done, err);
endinterface

// File: rtl/denormalizer.sv
// denormalizer: right-shifts a left-justified mantissa by -exp places, one bit per clock
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of denormalizer_if
//              start/in_mant/in_exp in; out_val/busy/done/err out (all registered)
//   Build option DENORM_ROUND_EN: round half up on the last shifted-out bit;
//   without it the result is truncated and no guard bit is kept.
module denormalizer #(parameter int n = 8) (
  input logic          clk,
  input logic          rst,
  denormalizer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [n-1:0] max_cnt = n'(n);
  state_t       state_q, state_d;
  logic [n-1:0] sh_q, sh_d;
  logic [n-1:0] cnt_q, cnt_d;
  logic [n-1:0] out_q, out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [n-1:0] neg;
  logic         pos;
`ifdef DENORM_ROUND_EN
  logic         guard_q, guard_d;
`endif
  assign neg = -bus.in_exp;
  assign pos = ~bus.in_exp[n-1] & (|bus.in_exp);
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef DENORM_ROUND_EN
    guard_d = guard_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        // a positive exponent cannot be denormalized: report it and saturate
        sh_d    = pos ? '1 : bus.in_mant;
        cnt_d   = pos ? '0 : (neg > max_cnt ? max_cnt : neg);
        err_d   = pos;
        busy_d  = 1'b1;
        state_d = SHIFT;
`ifdef DENORM_ROUND_EN
        guard_d = 1'b0;
`endif
      end
      SHIFT: if (cnt_q != '0) begin
        sh_d    = sh_q >> 1;
        cnt_d   = cnt_q - 1'b1;
`ifdef DENORM_ROUND_EN
        guard_d = sh_q[0];
`endif
      end else begin
`ifdef DENORM_ROUND_EN
        // after any shift the MSB is clear, so adding the guard cannot overflow
        out_d   = sh_q + {{(n-1){1'b0}}, guard_q};
`else
        out_d   = sh_q;
`endif
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
`ifdef DENORM_ROUND_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) guard_q <= 1'b0;
    else     guard_q <= guard_d;
  end
`endif
  assign bus.out_val = out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_denormalizer.sv
// tb_denormalizer: randomized scoreboard bench for denormalizer against an arithmetic model
module tb_denormalizer;
  localparam int n = 8;
  typedef struct {logic [n-1:0] val; logic err; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  denormalizer_if #(.n(n)) bus ();
  denormalizer #(.n(n)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [n-1:0] last_val = '0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [n-1:0] model(logic [n-1:0] m, logic [n-1:0] e);
    int ev = $signed(e);
    int s;
    longint r = longint'(m);
    if (ev > 0) return '1;
    s = (-ev > n) ? n : -ev;
`ifdef DENORM_ROUND_EN
    if (s > 0) r = r + (longint'(1) << (s - 1));
`endif
    return n'(r >> s);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_val", int'(bus.out_val), int'(e.val));
        chk("err", int'(bus.err), int'(e.err));
        chk("latency", cyc, e.cyc);
        chk("busy_at_done", int'(bus.busy), 1);
      end
    end
  end

  task automatic issue(logic [n-1:0] m, logic [n-1:0] e);
    int ev = $signed(e);
    int lat = (ev > 0) ? 0 : ((-ev > n) ? n : -ev);
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    bus.in_mant = m;
    bus.in_exp  = e;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.in_mant = n'($urandom);
    bus.in_exp  = n'($urandom);
    last_val    = model(m, e);
    sb.push_back('{model(m, e), ev > 0, cyc + lat + 1});
  endtask

  task automatic finish_op();
    int i;
    for (i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk("hold_out_val", int'(bus.out_val), int'(last_val));
  endtask

  task automatic op(logic [n-1:0] m, logic [n-1:0] e);
    issue(m, e);
    finish_op();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_mant = '0;
    bus.in_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val", int'(bus.out_val), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    rst = 1'b0;
    @(negedge clk);
    op(8'h80, 8'h00);
    op(8'hA0, 8'hFE);
    op(8'hB4, 8'hFD);
    op(8'hFF, 8'hF7);
    op(8'h90, 8'h01);
    op(8'h80, 8'h00);
    op(8'h00, 8'hFC);
    op(8'hC3, 8'h80);
    op(8'hFF, 8'h7F);
    // a second start while shifting must be ignored
    issue(8'hC0, 8'hFC);
    repeat (2) @(negedge clk);
    chk("busy_in_shift", int'(bus.busy), 1);
    bus.start = 1'b1;
    bus.in_mant = 8'hFF;
    bus.in_exp = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op();
    // reset while shifting aborts with no done pulse
    issue(8'hC0, 8'hFC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_val", int'(bus.out_val), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_err", int'(bus.err), 0);
    sb.delete();
    last_val = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_after_abort", int'(bus.busy), 0);
    for (int k = 0; k < 40; k++) begin
      logic [n-1:0] m = n'($urandom);
      logic [n-1:0] e = n'(int'($urandom_range(0, 12)) - 10);
      if ($urandom_range(0, 1) == 1) op(m, e);
      else issue(m, e);
    end
    finish_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
